iterative_shifter: RTL and testbench

ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

---
 rtl/iterative_shifter_pkg.sv | 30 +++
 rtl/iterative_shifter_step.sv | 42 ++++
 rtl/iterative_shifter.sv | 114 +++++++++++
 tb/tb_iterative_shifter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/iterative_shifter_pkg.sv
// Shared types and helpers for the iterative shifter: operation and FSM encodings,
// plus the effective step-count rule used when a request is accepted.
package shifter_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shifter_state_t;

    // Rotates wrap modulo the width; linear shifts saturate at the width.
    function automatic int unsigned effective_count(
        input shift_op_t   kind,
        input int unsigned amount,
        input int unsigned width
    );
        if (kind == ROR) begin
            return amount % width;
        end
        return (amount > width) ? width : amount;
    endfunction

endpackage

// File: rtl/iterative_shifter_step.sv
// One-position shift of an N-bit word for the selected operation; purely combinational.
// Reports the bit that leaves the word so the caller can track carry.
module shift_step
    import shifter_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] value,
    input  shift_op_t    op,
    output logic [N-1:0] next_value,
    output logic         out_bit
);

    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        unique case (op)
            SLL: begin
                next_value = {value[N-2:0], 1'b0};
                out_bit    = value[N-1];
            end
            SRL: begin
                next_value = {1'b0, value[N-1:1]};
                out_bit    = value[0];
            end
            // The MSB never changes during SRA, so it still holds the sign latched at accept.
            SRA: begin
                next_value = {value[N-1], value[N-1:1]};
                out_bit    = value[0];
            end
            ROR: begin
                next_value = {value[0], value[N-1:1]};
                out_bit    = value[0];
            end
            default: begin
                next_value = value;
                out_bit    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: accepts a request, applies one single-bit step per clock,
// then presents the result until the consumer takes it.
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned N  = 4,
    localparam int unsigned SW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [SW-1:0] shift,
    input  logic [1:0]    op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  y,
    output logic          carry,
    output logic          zero
);

    shifter_state_t state;
    shifter_state_t state_next;
    shift_op_t      op_in;
    shift_op_t      op_q;
    logic [SW-1:0]  count;
    logic [SW-1:0]  k_in;
    logic [N-1:0]   step_value;
    logic           step_bit;
    logic           accept;

    assign op_in  = shift_op_t'(op);
    assign k_in   = SW'(effective_count(op_in, 32'(shift), N));
    assign accept = in_valid && in_ready;
    assign zero   = (y == '0);

    shift_step #(
        .N (N)
    ) u_step (
        .value      (y),
        .op         (op_q),
        .next_value (step_value),
        .out_bit    (step_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (k_in == '0) ? DONE : SHIFT;
                end
            end
            // count holds the steps still to apply, so the step taken at count==1 is the last.
            SHIFT: begin
                if (count <= SW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y     <= '0;
            carry <= 1'b0;
            count <= '0;
            op_q  <= SLL;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        y     <= a;
                        carry <= 1'b0;
                        count <= k_in;
                        op_q  <= op_in;
                    end
                end
                SHIFT: begin
                    y     <= step_value;
                    carry <= step_bit;
                    count <= count - SW'(1);
                end
                default: begin
                    y     <= y;
                    carry <= carry;
                    count <= count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter (N=4): directed corner cases, random requests against an
// arithmetic reference model, backpressure, and reset during a shift.
module tb_iterative_shifter;

    localparam int N  = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [SW-1:0] shift;
    logic [1:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  y;
    logic          carry;
    logic          zero;

    int vectors    = 0;
    int miscompares = 0;

    iterative_shifter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .shift     (shift),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .carry     (carry),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: result of shifting by k positions at once, carry = last bit to leave.
    function automatic void model(input logic [3:0] av, input int s, input int o,
                                  output logic [3:0] ye, output logic ce, output int le);
        int k;
        logic [7:0] ext;
        k   = (o == 3) ? (s % N) : ((s > N) ? N : s);
        ext = {{4{av[3]}}, av};
        ce  = 1'b0;
        case (o)
            0: begin ye = 4'(av << k); if (k > 0) ce = av[N-k]; end
            1: begin ye = 4'(av >> k); if (k > 0) ce = av[k-1]; end
            2: begin ye = 4'(ext >> k); if (k > 0) ce = ext[k-1]; end
            default: begin ye = 4'((av >> k) | (av << (N - k))); if (k > 0) ce = av[k-1]; end
        endcase
        le = k + 1;
    endfunction

    // Presents one request from IDLE (#1 after an edge) and waits for out_valid.
    // lat counts edges from the accept edge; returns sampled outputs in the DONE cycle.
    task automatic issue(input logic [3:0] av, input logic [2:0] sv, input logic [1:0] ov,
                         output int lat, output logic [3:0] yo, output logic co, output logic zo);
        a = av; shift = sv; op = ov; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        yo = y; co = carry; zo = zero;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; shift = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++; if (y !== 4'b0000) begin miscompares++; $display("FAIL reset_y got=%b exp=0000", y); end
        vectors++; if (carry !== 1'b0) begin miscompares++; $display("FAIL reset_carry got=%b exp=0", carry); end
        vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero got=%b exp=1", zero); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [3:0] ta [10] = '{4'b1111, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1011, 4'b0110};
        logic [2:0] ts [10] = '{3'd2,    3'd1,    3'd5,    3'd1,    3'd5,    3'd4,    3'd4,    3'd0,    3'd7,    3'd3};
        logic [1:0] to [10] = '{2'd1,    2'd2,    2'd2,    2'd3,    2'd3,    2'd3,    2'd0,    2'd0,    2'd1,    2'd3};
        int lat, le;
        logic [3:0] yo, ye;
        logic co, ce, zo;
        for (int i = 0; i < 10; i++) begin
            issue(ta[i], ts[i], to[i], lat, yo, co, zo);
            model(ta[i], int'(ts[i]), int'(to[i]), ye, ce, le);
            vectors++; if (yo !== ye) begin miscompares++; $display("FAIL dir%0d_y got=%b exp=%b", i, yo, ye); end
            vectors++; if (co !== ce) begin miscompares++; $display("FAIL dir%0d_carry got=%b exp=%b", i, co, ce); end
            vectors++; if (zo !== (ye == 4'b0)) begin miscompares++; $display("FAIL dir%0d_zero got=%b exp=%b", i, zo, ye == 4'b0); end
            vectors++; if (lat !== le) begin miscompares++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, le); end
        end
    endtask

    task automatic test_random();
        int lat, le;
        logic [3:0] av, yo, ye;
        logic [2:0] sv;
        logic [1:0] ov;
        logic co, ce, zo;
        for (int i = 0; i < 60; i++) begin
            av = 4'($urandom); sv = 3'($urandom); ov = 2'($urandom);
            issue(av, sv, ov, lat, yo, co, zo);
            model(av, int'(sv), int'(ov), ye, ce, le);
            vectors++; if (yo !== ye || co !== ce || zo !== (ye == 4'b0) || lat !== le)
                begin miscompares++; $display("FAIL rand%0d a=%b s=%0d op=%0d got y=%b c=%b z=%b lat=%0d exp y=%b c=%b lat=%0d",
                                              i, av, sv, ov, yo, co, zo, lat, ye, ce, le); end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] held_y;
        logic held_c;
        out_ready = 1'b0;
        a = 4'b1111; shift = 3'd2; op = 2'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 4'b1010;
        for (int c = 1; c <= 2; c++) begin
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_shift_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
            @(posedge clk); #1;
        end
        held_y = 4'b0011; held_c = 1'b1;
        for (int c = 0; c < 4; c++) begin
            vectors++; if (out_valid !== 1'b1 || y !== held_y || carry !== held_c || in_ready !== 1'b0)
                begin miscompares++; $display("FAIL bp_hold cyc=%0d got ov=%b y=%b c=%b ir=%b exp ov=1 y=%b c=%b ir=0",
                                              c, out_valid, y, carry, in_ready, held_y, held_c); end
            if (c < 3) begin @(posedge clk); #1; end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== held_y || carry !== held_c)
            begin miscompares++; $display("FAIL bp_release got ov=%b ir=%b y=%b c=%b exp ov=0 ir=1 y=%b c=%b",
                                          out_valid, in_ready, y, carry, held_y, held_c); end
    endtask

    task automatic test_reset_mid_op();
        int lat, le;
        logic [3:0] yo, ye;
        logic co, ce, zo;
        a = 4'b1111; shift = 3'd3; op = 2'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        vectors++; if (y !== 4'b0000 || out_valid !== 1'b0 || in_ready !== 1'b1 || zero !== 1'b1)
            begin miscompares++; $display("FAIL midreset got y=%b ov=%b ir=%b z=%b exp y=0000 ov=0 ir=1 z=1",
                                          y, out_valid, in_ready, zero); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_no_partial got ov=%b exp=0", out_valid); end
        issue(4'b1111, 3'd3, 2'd1, lat, yo, co, zo);
        model(4'b1111, 3, 1, ye, ce, le);
        vectors++; if (yo !== ye || co !== ce || lat !== le)
            begin miscompares++; $display("FAIL after_reset got y=%b c=%b lat=%0d exp y=%b c=%b lat=%0d", yo, co, lat, ye, ce, le); end
    endtask

    task automatic test_back_to_back();
        int lat, le;
        logic [3:0] yo, ye;
        logic co, ce, zo;
        issue(4'b1000, 3'd1, 2'd2, lat, yo, co, zo);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        issue(4'b1000, 3'd5, 2'd2, lat, yo, co, zo);
        model(4'b1000, 5, 2, ye, ce, le);
        vectors++; if (yo !== ye || co !== ce || lat !== le)
            begin miscompares++; $display("FAIL b2b_second got y=%b c=%b lat=%0d exp y=%b c=%b lat=%0d", yo, co, lat, ye, ce, le); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
